// File: rtl/cpu_sequencer.sv
// Control sequencer for the non-pipelined Harvard CPU: fetch handshake, instruction
// register, one-hot phase bus for the ALU, PC, zero flag and branch/halt resolution.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  input  logic [15:0] alu_result,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic [2:0]  state,
  output logic        zero_flag,
  output logic        halted
);

  // Encodings double as the one-hot phase bus the ALU decodes.
  typedef enum logic [2:0] {
    FETCH = 3'b001,
    EXEC1 = 3'b010,
    EXEC2 = 3'b100,
    HALT  = 3'b000
  } state_t;

  state_t      state_q, state_n;
  logic [15:0] pc_n, inst_n, offset, pc_inc, pc_tgt;
  logic        zf_n;
  logic        is_arith, is_ldr, is_b, is_bz, is_bnz, is_halt;

  assign is_arith = inst[15];
  assign is_ldr   = (inst[15:12] == 4'b1101);
  assign is_b     = (inst[15:12] == 4'b0100);
  assign is_bz    = (inst[15:12] == 4'b0101);
  assign is_bnz   = (inst[15:12] == 4'b0110);
  assign is_halt  = (inst[15:12] == 4'b0111);

  assign offset = {{8{inst[7]}}, inst[7:0]};
  assign pc_inc = pc + 16'd1;
  assign pc_tgt = pc + offset;

  always_comb begin
    state_n = state_q;
    pc_n    = pc;
    inst_n  = inst;
    zf_n    = zero_flag;
    case (state_q)
      FETCH: begin
        if (imem_valid) begin
          inst_n  = imem_data;
          state_n = EXEC1;
        end
      end
      EXEC1: begin
        if (is_arith) zf_n = (alu_result == 16'h0000);
        state_n = FETCH;
        if (is_ldr)       state_n = EXEC2;
        else if (is_b)    pc_n = pc_tgt;
        else if (is_bz)   pc_n = zero_flag ? pc_tgt : pc_inc;
        else if (is_bnz)  pc_n = zero_flag ? pc_inc : pc_tgt;
        else if (is_halt) state_n = HALT;
        else              pc_n = pc_inc;
      end
      EXEC2: begin
        pc_n    = pc_inc;
        state_n = FETCH;
      end
      HALT: begin
        if (run) begin
          pc_n    = pc_inc;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc        <= RESET_PC;
      inst      <= 16'h0000;
      zero_flag <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_n;
      pc        <= pc_n;
      inst      <= inst_n;
      zero_flag <= zf_n;
      halted    <= (state_n == HALT);
    end
  end

  assign state    = state_q;
  assign imem_req = (state_q == FETCH);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset, fetch, LDR, branches, wait states,
// PC wrap, halt/resume and zero-flag behaviour.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] alu_result;
  logic        run;
  logic        imem_req;
  logic [15:0] pc;
  logic [15:0] inst;
  logic [2:0]  state;
  logic        zero_flag;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  cpu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_data(imem_data), .imem_valid(imem_valid),
    .alu_result(alu_result), .run(run), .imem_req(imem_req), .pc(pc),
    .inst(inst), .state(state), .zero_flag(zero_flag), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fetch (zero wait) and execute a single-EXEC1 instruction.
  task automatic exec(input logic [15:0] word, input logic [15:0] alu);
    imem_valid = 1'b1;
    imem_data  = word;
    alu_result = alu;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; imem_data = 16'h0000; imem_valid = 1'b0; alu_result = 16'h0000; run = 1'b0;
    @(negedge clk);
    chk("rst_state", {13'b0, state}, 16'h0001);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_zf", {15'b0, zero_flag}, 16'h0000);
    chk("rst_req", {15'b0, imem_req}, 16'h0001);
    chk("rst_halted", {15'b0, halted}, 16'h0000);

    // First fetch, then asynchronous reset in the middle of EXEC1.
    reset = 1'b0; imem_valid = 1'b1; imem_data = 16'h8123; alu_result = 16'h0000;
    step();
    chk("f1_state", {13'b0, state}, 16'h0002);
    chk("f1_inst", inst, 16'h8123);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", {13'b0, state}, 16'h0001);
    chk("arst_inst", inst, 16'h0000);
    chk("arst_req", {15'b0, imem_req}, 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("f2_state", {13'b0, state}, 16'h0002);
    step();
    chk("f2_state_back", {13'b0, state}, 16'h0001);
    chk("f2_pc", pc, 16'h0001);
    chk("f2_zf_set", {15'b0, zero_flag}, 16'h0001);
    exec(16'h8123, 16'h0005);
    chk("f3_pc", pc, 16'h0002);
    chk("f3_zf_clr", {15'b0, zero_flag}, 16'h0000);

    // B +3 from pc=2 to reach pc=5.
    exec(16'h4003, 16'h0000);
    chk("b_pc5", pc, 16'h0005);

    // LDR: FETCH, EXEC1, EXEC2, then pc advances.
    imem_data = 16'hD045; alu_result = 16'h0000;
    step();
    chk("ldr_s1", {13'b0, state}, 16'h0002);
    chk("ldr_pc_e1", pc, 16'h0005);
    step();
    chk("ldr_s2", {13'b0, state}, 16'h0004);
    chk("ldr_pc_e2", pc, 16'h0005);
    chk("ldr_zf", {15'b0, zero_flag}, 16'h0001);
    chk("ldr_req_e2", {15'b0, imem_req}, 16'h0000);
    step();
    chk("ldr_s3", {13'b0, state}, 16'h0001);
    chk("ldr_pc6", pc, 16'h0006);

    // Branches with zero_flag=1.
    exec(16'h4004, 16'h0005);
    chk("b_pc10", pc, 16'h000A);
    exec(16'h50FE, 16'h0005);
    chk("bz_taken", pc, 16'h0008);
    exec(16'h4002, 16'h0005);
    exec(16'h60FE, 16'h0005);
    chk("bnz_not_taken", pc, 16'h000B);
    chk("bnz_zf_kept", {15'b0, zero_flag}, 16'h0001);

    // Negative offset from 11 lands on FFFF; then wait states and wrap.
    exec(16'h40F4, 16'h0000);
    chk("b_neg_pc", pc, 16'hFFFF);
    imem_valid = 1'b0; imem_data = 16'h2000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_state", {13'b0, state}, 16'h0001);
      chk("wait_pc", pc, 16'hFFFF);
    end
    exec(16'h2000, 16'h0000);
    chk("wrap_pc", pc, 16'h0000);

    // Halt at pc=20, resume after 4 cycles.
    exec(16'h4014, 16'h0000);
    chk("b_pc20", pc, 16'h0014);
    imem_data = 16'h7000;
    step();
    step();
    chk("halt_state", {13'b0, state}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      chk("halt_halted", {15'b0, halted}, 16'h0001);
      chk("halt_req", {15'b0, imem_req}, 16'h0000);
      chk("halt_pc", pc, 16'h0014);
      step();
    end
    run = 1'b1;
    step();
    run = 1'b0;
    chk("resume_state", {13'b0, state}, 16'h0001);
    chk("resume_pc", pc, 16'h0015);
    chk("resume_halted", {15'b0, halted}, 16'h0000);

    // Zero flag: arithmetic sets it, a NOP leaves it.
    exec(16'h8000, 16'h0005);
    chk("zf_clear_arith", {15'b0, zero_flag}, 16'h0000);
    exec(16'h8000, 16'h0000);
    chk("zf_set_arith", {15'b0, zero_flag}, 16'h0001);
    exec(16'h2000, 16'h0005);
    chk("zf_nop_hold", {15'b0, zero_flag}, 16'h0001);
    chk("nop_pc", pc, 16'h0018);

    // Offset 0 branches to self; run outside HALT has no effect.
    run = 1'b1;
    exec(16'h4000, 16'h0000);
    run = 1'b0;
    chk("b_self_pc", pc, 16'h0018);
    chk("b_self_state", {13'b0, state}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
